// File: rtl/fnv_pkg.sv
// Shared definitions for the FNV stream hasher: FSM states, FNV constants,
// and the shift tables that drive the shift-add multiplier.
package fnv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } fnv_state_t;

    localparam logic [31:0] FNV_OFFSET_32 = 32'h811C9DC5;
    localparam logic [63:0] FNV_OFFSET_64 = 64'hCBF29CE484222325;
    localparam logic [31:0] FNV_PRIME_32  = 32'h01000193;
    localparam logic [63:0] FNV_PRIME_64  = 64'h00000100000001B3;

    // Popcount of each prime, i.e. the number of multiply steps.
    localparam int P32 = 6;
    localparam int P64 = 7;

    // Positions of the set bits of each prime, ascending.
    localparam int unsigned SHIFT_32 [P32] = '{0, 1, 4, 7, 8, 24};
    localparam int unsigned SHIFT_64 [P64] = '{0, 1, 4, 5, 7, 8, 40};

    // Offset basis for the given hash width, zero-extended to 64 bits.
    function automatic logic [63:0] offset_basis(input int hash_w);
        return (hash_w == 64) ? FNV_OFFSET_64 : {32'h0, FNV_OFFSET_32};
    endfunction

    // Shift amount for multiply step idx; out-of-range steps contribute nothing.
    function automatic int unsigned prime_shift(input int hash_w, input int idx);
        if (hash_w == 64) begin
            return (idx < P64) ? SHIFT_64[idx] : 0;
        end
        return (idx < P32) ? SHIFT_32[idx] : 0;
    endfunction

endpackage

// File: rtl/fnv_shift_add_mul.sv
// Serial multiplier by the FNV prime: one set bit of the prime per cycle.
// start loads the operand and clears the accumulator; done marks the final
// step, with product already holding the completed result that cycle.
module fnv_shift_add_mul
    import fnv_pkg::*;
#(
    parameter int HASH_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic [HASH_W-1:0] operand_in,
    output logic              done,
    output logic [HASH_W-1:0] product
);

    localparam int P = (HASH_W == 64) ? P64 : P32;

    logic [HASH_W-1:0] operand_q;
    logic [HASH_W-1:0] acc_q;
    logic [HASH_W-1:0] acc_next;
    logic [2:0]        step_q;
    logic              busy_q;

    // Next accumulator value: add the operand shifted to the current prime bit.
    always_comb begin
        acc_next = acc_q + (operand_q << prime_shift(HASH_W, int'(step_q)));
        done     = busy_q && (step_q == 3'(P - 1));
        product  = acc_next;
    end

    // Operand, accumulator and step counter; reset outranks abort outranks start.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_q <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
        end else if (abort) begin
            acc_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            operand_q <= operand_in;
            acc_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_next;
            if (done) begin
                step_q <= '0;
                busy_q <= 1'b0;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/fnv_stream_hasher.sv
// Byte-stream FNV-1 / FNV-1a hasher with valid/ready handshakes on both sides.
// Optional byte counter enabled by defining FNV_BYTE_COUNT_EN; otherwise
// byte_count is tied to zero.
module fnv_stream_hasher
    import fnv_pkg::*;
#(
    parameter int HASH_W = 32,
    parameter bit FNV1A  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HASH_W-1:0] out_hash,
    output logic [15:0]       byte_count
);

    localparam logic [HASH_W-1:0] OFFSET = HASH_W'(offset_basis(HASH_W));

    fnv_state_t        state_q;
    fnv_state_t        state_d;
    logic [HASH_W-1:0] hash_q;
    logic [HASH_W-1:0] mul_operand;
    logic [HASH_W-1:0] mul_product;
    logic [7:0]        byte_q;
    logic              last_q;
    logic              accept;
    logic              mul_done;
    logic              out_fire;

    // FNV-1a folds the byte in before the multiply, FNV-1 after it.
    assign mul_operand = FNV1A ? (hash_q ^ {{(HASH_W-8){1'b0}}, in_data}) : hash_q;
    assign out_hash    = hash_q;

    fnv_shift_add_mul #(
        .HASH_W (HASH_W)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .abort      (clear),
        .start      (accept),
        .operand_in (mul_operand),
        .done       (mul_done),
        .product    (mul_product)
    );

    // Next-state and handshake outputs; clear forces IDLE and blocks input.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !clear;
                if (in_valid && !clear) begin
                    accept  = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
        out_fire = out_valid && out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Running hash: restart on reset/clear/digest handoff, update after multiply.
    always_ff @(posedge clk) begin
        if (reset || clear || out_fire) begin
            hash_q <= OFFSET;
        end else if (state_q == ST_MUL && mul_done) begin
            hash_q <= FNV1A ? mul_product
                            : (mul_product ^ {{(HASH_W-8){1'b0}}, byte_q});
        end
    end

    // Latch the accepted byte and its last flag for use after the multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            byte_q <= in_data;
            last_q <= in_last;
        end
    end

`ifdef FNV_BYTE_COUNT_EN
    logic [15:0] count_q;

    // Saturating count of bytes accepted in the current message.
    always_ff @(posedge clk) begin
        if (reset || clear || out_fire) begin
            count_q <= '0;
        end else if (accept && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign byte_count = count_q;
`else
    assign byte_count = '0;
`endif

endmodule

// File: tb/tb_fnv_stream_hasher.sv
// Self-checking bench for fnv_stream_hasher: three instances (32-bit FNV-1a,
// 32-bit FNV-1, 64-bit FNV-1a) checked against an arithmetic FNV model.
module tb_fnv_stream_hasher;

    typedef logic [7:0] msg_t [$];

    localparam logic [63:0] OFF32 = 64'h0000_0000_811C_9DC5;
    localparam logic [63:0] OFF64 = 64'hCBF2_9CE4_8422_2325;
    localparam logic [63:0] PR32  = 64'h0000_0000_0100_0193;
    localparam logic [63:0] PR64  = 64'h0000_0100_0000_01B3;
`ifdef FNV_BYTE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    int          sel;
    logic [2:0]  rdy, vld;
    logic [31:0] h_a, h_b;
    logic [63:0] h_c;
    logic [15:0] c_a, c_b, c_c;

    logic        obs_ready, obs_valid;
    logic [63:0] obs_hash;
    logic [15:0] obs_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    msg_t sent;

    always #5 clk = ~clk;

    fnv_stream_hasher #(.HASH_W(32), .FNV1A(1'b1)) dut_a (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid && sel == 0), .in_ready(rdy[0]),
        .in_data(in_data), .in_last(in_last),
        .out_valid(vld[0]), .out_ready(out_ready && sel == 0),
        .out_hash(h_a), .byte_count(c_a));

    fnv_stream_hasher #(.HASH_W(32), .FNV1A(1'b0)) dut_b (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid && sel == 1), .in_ready(rdy[1]),
        .in_data(in_data), .in_last(in_last),
        .out_valid(vld[1]), .out_ready(out_ready && sel == 1),
        .out_hash(h_b), .byte_count(c_b));

    fnv_stream_hasher #(.HASH_W(64), .FNV1A(1'b1)) dut_c (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid && sel == 2), .in_ready(rdy[2]),
        .in_data(in_data), .in_last(in_last),
        .out_valid(vld[2]), .out_ready(out_ready && sel == 2),
        .out_hash(h_c), .byte_count(c_c));

    // Route the selected instance's outputs to one set of observation signals.
    always_comb begin
        obs_ready = rdy[0];
        obs_valid = vld[0];
        obs_hash  = {32'h0, h_a};
        obs_count = c_a;
        case (sel)
            1: begin
                obs_ready = rdy[1]; obs_valid = vld[1];
                obs_hash  = {32'h0, h_b}; obs_count = c_b;
            end
            2: begin
                obs_ready = rdy[2]; obs_valid = vld[2];
                obs_hash  = h_c; obs_count = c_c;
            end
            default: ;
        endcase
    end

    function automatic int hw_of(input int s);
        return (s == 2) ? 64 : 32;
    endfunction

    function automatic int steps_of(input int s);
        return (s == 2) ? 7 : 6;
    endfunction

    function automatic logic [63:0] offset_of(input int s);
        return (s == 2) ? OFF64 : OFF32;
    endfunction

    // Reference FNV over a byte queue using plain modular multiplication.
    function automatic logic [63:0] fnv_ref(input msg_t m, input int s);
        logic [63:0] h;
        logic [63:0] prime;
        bit          fnv1a;
        h     = offset_of(s);
        prime = (hw_of(s) == 64) ? PR64 : PR32;
        fnv1a = (s != 1);
        foreach (m[i]) begin
            if (fnv1a) h = (h ^ {56'h0, m[i]}) * prime;
            else       h = (h * prime) ^ {56'h0, m[i]};
            if (hw_of(s) == 32) h = h & 64'h0000_0000_FFFF_FFFF;
        end
        return h;
    endfunction

    function automatic logic [63:0] exp_count();
        return CNT_EN ? 64'(sent.size()) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte, wait (bounded) for acceptance, then check MUL timing
    // and the running hash once the multiply completes.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit keep_valid);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        n = 0;
        while (!obs_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(obs_ready), 64'd1);
        if (!obs_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        sent.push_back(b);
        in_valid = keep_valid;
        for (int k = 0; k < steps_of(sel); k++) begin
            check("mul_ready_low", 64'(obs_ready), 64'd0);
            check("mul_valid_low", 64'(obs_valid), 64'd0);
            @(negedge clk);
        end
        check("post_mul_ready", 64'(obs_ready), 64'(!last));
        check("post_mul_valid", 64'(obs_valid), 64'(last));
        check("running_hash", obs_hash, fnv_ref(sent, sel));
        check("byte_count", 64'(obs_count), exp_count());
    endtask

    task automatic send_msg(input msg_t m, input bit back_to_back);
        foreach (m[i]) begin
            send_byte(m[i], i == m.size() - 1, back_to_back && (i != m.size() - 1));
        end
    endtask

    // Hold the digest for a while, then take it and check the restart state.
    task automatic take_digest(input int hold);
        out_ready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(obs_valid), 64'd1);
            check("hold_hash", obs_hash, fnv_ref(sent, sel));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        sent.delete();
        check("taken_valid", 64'(obs_valid), 64'd0);
        check("taken_ready", 64'(obs_ready), 64'd1);
        check("taken_hash", obs_hash, offset_of(sel));
        check("taken_count", 64'(obs_count), 64'd0);
    endtask

    task automatic check_restart(input string tag);
        #1;
        check({tag, "_hash"}, obs_hash, offset_of(sel));
        check({tag, "_count"}, 64'(obs_count), 64'd0);
        check({tag, "_ready"}, 64'(obs_ready), 64'd1);
        check({tag, "_valid"}, 64'(obs_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t foobar;
        msg_t msg_a;
        msg_t rnd;
        foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
        msg_a  = '{8'h61};

        sel = 0; reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            check_restart("reset_state");
        end
        sel = 0;

        // Single "a" on each flavour, against the published vectors.
        send_msg(msg_a, 1'b0);
        check("a_1a32_vec", obs_hash, 64'hE40C292C);
        take_digest(0);
        sel = 1;
        send_msg(msg_a, 1'b0);
        check("a_fnv1_32_vec", obs_hash, 64'h050C5D7E);
        take_digest(1);
        sel = 2;
        send_msg(msg_a, 1'b0);
        check("a_1a64_vec", obs_hash, 64'hAF63DC4C8601EC8C);
        take_digest(0);

        // "foobar" back-to-back, digest held for 5 cycles.
        sel = 0;
        send_msg(foobar, 1'b1);
        check("foobar_vec", obs_hash, 64'hBF9CF968);
        check("foobar_count", 64'(obs_count), CNT_EN ? 64'd6 : 64'd0);
        take_digest(5);

        // A byte offered alongside clear must be refused.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; clear = 1'b1;
        #1;
        check("clear_blocks_ready", 64'(obs_ready), 64'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check_restart("clear_idle");

        // clear during the multiply of the third byte.
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h6F, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h6F; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sent.delete();
        check_restart("clear_mid_mul");
        repeat (8) @(negedge clk);
        check("clear_no_resume", obs_hash, OFF32);
        send_msg(msg_a, 1'b0);
        check("after_clear_a", obs_hash, 64'hE40C292C);
        take_digest(0);

        // reset during the multiply of the third byte.
        send_byte(8'h66, 1'b0, 1'b0);
        send_byte(8'h6F, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h6F; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sent.delete();
        check_restart("reset_mid_mul");
        repeat (8) @(negedge clk);
        check("reset_no_resume", obs_hash, OFF32);
        send_msg(msg_a, 1'b0);
        check("after_reset_a", obs_hash, 64'hE40C292C);

        // reset while a digest is pending drops it.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sent.delete();
        check_restart("reset_in_done");

        // clear while a digest is pending drops it.
        send_msg(msg_a, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sent.delete();
        check_restart("clear_in_done");

        // Random messages on every flavour.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int m = 0; m < 4; m++) begin
                rnd.delete();
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
                    rnd.push_back(8'($urandom));
                end
                send_msg(rnd, 1'($urandom));
                take_digest(int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
